vga_sync_timer: RTL and testbench
=================================

Name: vga_sync_timer

Overview:
- Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock.
- Produces the `pixel_x`/`pixel_y`/`video_on` stream consumed by `generador_imagenes`, and drives the `hsync`/`vsync` pins.
- Pixel rate is derived with an internal clock-enable divider. There is no second clock domain.
- Sits directly upstream of the image generator and RGB output register in the display top level.

Parameters:
- TICK_DIV, 4, clk cycles per pixel (100 MHz / 4 = 25 MHz pixel tick); must be >= 2
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- hsync  out  1  horizontal sync, active-low, registered
- vsync  out  1  vertical sync, active-low, registered
- video_on  out  1  high while h_count < H_DISPLAY and v_count < V_DISPLAY
- p_tick  out  1  one-clk pixel enable pulse, every TICK_DIV clks
- pixel_x  out  10  current horizontal count (0..H_TOTAL-1)
- pixel_y  out  10  current vertical count (0..V_TOTAL-1)
- frame_start  out  1  one-clk pulse on the first clk of pixel (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525.
- Reset (reset=0, asynchronous): div_cnt=0, h_count=0, v_count=0, hsync=1, vsync=1, p_tick=0, frame_start=0.
  - video_on therefore reads 1 during reset, because the counters are at (0,0).
  - Release is synchronous to the next clk edge.
- Divider: div_cnt counts 0..TICK_DIV-1 and wraps. p_tick (registered) is 1 for exactly the clk cycle after div_cnt==TICK_DIV-1.
  - First p_tick is on the TICK_DIV-th rising edge after reset release.
- Counters advance only on clk edges where p_tick==1:
  - h_count: if h_count==H_TOTAL-1, then h_count←0; otherwise h_count+1.
  - v_count changes only when h_count wraps: if v_count==V_TOTAL-1, then v_count←0; otherwise v_count+1.
  - Simultaneous wrap (799,524) → (0,0) in one tick.
- Sync outputs are registered and computed from the next-state counts, so they change on the same edge as the counters (zero skew vs pixel_x/pixel_y):
  - hsync = 0 iff 656 <= h_next <= 751 (H_DISPLAY+H_FRONT .. H_DISPLAY+H_FRONT+H_SYNC-1).
  - vsync = 0 iff 490 <= v_next <= 491.
  - Both are otherwise 1.
- video_on is combinational from the h_count/v_count registers. pixel_x = h_count; pixel_y = v_count (direct register outputs, 0-cycle latency).
- frame_start is a registered pulse, 1 for exactly one clk, on the edge where counts transition (799,524)→(0,0). It is 0 at reset and not asserted on reset release.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Any out-of-range value (not reachable in normal operation) wraps to 0 at the next tick.
- Reset asserted mid-frame: all state returns to reset values immediately, regardless of clk.

Optional Feature:
- Macro VGA_SYNC_FRAME_COUNT_EN.
- When defined:
  - Adds output port `frame_cnt` [7:0].
  - `frame_cnt` increments by 1 (mod 256) on every frame_start pulse, in the same clk as the pulse.
  - Reset value 0; wraps 255→0.
  - Used by the image generator for blink/animation timing.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset held low 10 clks, then released → hsync=1, vsync=1, pixel_x=0, pixel_y=0, video_on=1 during reset; first p_tick on 4th edge after release; pixel_x=1 one clk after that tick.
- Run 1 line (3200 clks) → p_tick period exactly 4 clks; pixel_x 0..799 then 0; pixel_y 0→1 on the same edge as the x wrap; video_on falls when pixel_x=640.
- Observe hsync per line → low for exactly 96 ticks (384 clks), asserting on the edge where pixel_x becomes 656 and deasserting where it becomes 752.
- Run 1 full frame (1,680,000 clks) → vsync low exactly while pixel_y is 490–491 (1600 ticks); frame_start high exactly one clk at the (0,0) transition; frame period 420,000 ticks.
- Assert reset at pixel (300,200), mid-tick → all outputs return to reset values asynchronously; after release, counting restarts at (0,0) with no frame_start pulse.
- With VGA_SYNC_FRAME_COUNT_EN defined, run 257 frames → frame_cnt reads 1 after the first frame_start, 255 after the 255th, wraps to 0 at the 256th, reads 1 after the 257th.

Source files
------------

// File: rtl/vga_sync_timer.sv
// VGA sync generator: 640x480@60 timing from a 100 MHz clock using a pixel clock-enable.
// Optional frame counter output enabled by defining VGA_SYNC_FRAME_COUNT_EN.
module vga_sync_timer #(
  parameter int TICK_DIV  = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
`ifdef VGA_SYNC_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(TICK_DIV);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             p_tick_reg;
  logic [9:0]       h_count_reg, h_next;
  logic [9:0]       v_count_reg, v_next;
  logic             hsync_reg, vsync_reg;
  logic             frame_start_reg, frame_start_next;
  logic             h_wrap, v_wrap;

  // Wrap on >= so any out-of-range count recovers to 0 at the next tick.
  always_comb begin
    h_wrap           = (h_count_reg >= H_MAX);
    v_wrap           = (v_count_reg >= V_MAX);
    h_next           = h_count_reg;
    v_next           = v_count_reg;
    frame_start_next = 1'b0;
    if (p_tick_reg) begin
      h_next = h_wrap ? 10'd0 : h_count_reg + 10'd1;
      if (h_wrap) begin
        v_next = v_wrap ? 10'd0 : v_count_reg + 10'd1;
      end
      frame_start_next = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_reg     <= '0;
      p_tick_reg      <= 1'b0;
      h_count_reg     <= '0;
      v_count_reg     <= '0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      div_cnt_reg     <= (div_cnt_reg >= DIV_MAX) ? '0 : div_cnt_reg + DIV_W'(1);
      p_tick_reg      <= (div_cnt_reg == DIV_MAX);
      h_count_reg     <= h_next;
      v_count_reg     <= v_next;
      // Syncs come from next-state counts so they switch on the same edge as pixel_x/pixel_y.
      hsync_reg       <= !((h_next >= HS_START) && (h_next <= HS_END));
      vsync_reg       <= !((v_next >= VS_START) && (v_next <= VS_END));
      frame_start_reg <= frame_start_next;
    end
  end

`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic [7:0] frame_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_reg <= '0;
    end else if (frame_start_next) begin
      frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign p_tick      = p_tick_reg;
  assign pixel_x     = h_count_reg;
  assign pixel_y     = v_count_reg;
  assign frame_start = frame_start_reg;
  assign video_on    = (h_count_reg < H_VIS) && (v_count_reg < V_VIS);

endmodule

// File: tb/tb_vga_sync_timer.sv
// Directed bench: instance a uses the default 640x480 timing, instance b a tiny 15x10 raster
// (TICK_DIV=2) so whole frames, vsync and mid-frame reset fit in a short run.
module tb_vga_sync_timer;

  logic       clk;
  logic       reset;
  logic       a_hs, a_vs, a_von, a_pt, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_hs, b_vs, b_von, b_pt, b_fs;
  logic [9:0] b_x, b_y;
`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic [7:0] a_fc, b_fc;
`endif

  int checks = 0;
  int errors = 0;

  vga_sync_timer dut_a (
    .clk         (clk),
    .reset       (reset),
    .hsync       (a_hs),
    .vsync       (a_vs),
    .video_on    (a_von),
    .p_tick      (a_pt),
    .pixel_x     (a_x),
    .pixel_y     (a_y),
    .frame_start (a_fs)
`ifdef VGA_SYNC_FRAME_COUNT_EN
    ,
    .frame_cnt   (a_fc)
`endif
  );

  vga_sync_timer #(
    .TICK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
    .hsync       (b_hs),
    .vsync       (b_vs),
    .video_on    (b_von),
    .p_tick      (b_pt),
    .pixel_x     (b_x),
    .pixel_y     (b_y),
    .frame_start (b_fs)
`ifdef VGA_SYNC_FRAME_COUNT_EN
    ,
    .frame_cnt   (b_fc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a_hsync"}, a_hs, 1);
    check({tag, "_a_vsync"}, a_vs, 1);
    check({tag, "_a_x"}, a_x, 0);
    check({tag, "_a_y"}, a_y, 0);
    check({tag, "_a_video_on"}, a_von, 1);
    check({tag, "_a_p_tick"}, a_pt, 0);
    check({tag, "_a_frame_start"}, a_fs, 0);
    check({tag, "_b_hsync"}, b_hs, 1);
    check({tag, "_b_vsync"}, b_vs, 1);
    check({tag, "_b_x"}, b_x, 0);
    check({tag, "_b_y"}, b_y, 0);
    check({tag, "_b_p_tick"}, b_pt, 0);
    check({tag, "_b_frame_start"}, b_fs, 0);
`ifdef VGA_SYNC_FRAME_COUNT_EN
    check({tag, "_b_frame_cnt"}, b_fc, 0);
`endif
  endtask

  initial begin
    int adv_a, adv_b, ha, va, hb, vb;
    int a_hs_low, b_vs_low, b_fs_cnt;
    bit found;

    // Reset held for 10 clocks.
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");

    // Release between edges; n counts rising edges since release.
    reset = 1'b1;
    a_hs_low = 0;
    b_vs_low = 0;
    b_fs_cnt = 0;
    for (int n = 1; n <= 3300; n++) begin
      @(negedge clk);
      adv_a = (n - 1) / 4;
      ha    = adv_a % 800;
      va    = adv_a / 800;
      check("a_p_tick", a_pt, (n % 4 == 0));
      check("a_x", a_x, ha);
      check("a_y", a_y, va);
      check("a_hsync", a_hs, !(ha >= 656 && ha <= 751));
      check("a_vsync", a_vs, 1);
      check("a_video_on", a_von, (ha < 640 && va < 480));
      check("a_frame_start", a_fs, 0);
      if (!a_hs) a_hs_low++;

      adv_b = (n - 1) / 2;
      hb    = adv_b % 15;
      vb    = (adv_b / 15) % 10;
      check("b_p_tick", b_pt, (n % 2 == 0));
      check("b_x", b_x, hb);
      check("b_y", b_y, vb);
      check("b_hsync", b_hs, !(hb >= 10 && hb <= 12));
      check("b_vsync", b_vs, !(vb >= 7 && vb <= 8));
      check("b_video_on", b_von, (hb < 8 && vb < 6));
      check("b_frame_start", b_fs, (n % 2 == 1) && (n >= 3) && (adv_b % 150 == 0));
      if (!b_vs) b_vs_low++;
      if (b_fs) b_fs_cnt++;
    end
    check("a_hsync_low_clks", a_hs_low, 384);
    check("b_vsync_low_clks", b_vs_low, 660);
    check("b_frame_start_count", b_fs_cnt, 10);
`ifdef VGA_SYNC_FRAME_COUNT_EN
    check("b_frame_cnt_after_run", b_fc, 10);
`endif

    // Mid-frame, mid-tick reset on the small raster at pixel (5,3).
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (b_x == 10'd5 && b_y == 10'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("b_reach_5_3", found, 1);
    #2 reset = 1'b0;
    #1 check_reset_state("async_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check("rel_a_p_tick", a_pt, (n % 4 == 0));
      check("rel_a_x", a_x, (n - 1) / 4);
      check("rel_b_p_tick", b_pt, (n % 2 == 0));
      check("rel_b_x", b_x, (n - 1) / 2);
      check("rel_b_y", b_y, 0);
      check("rel_b_frame_start", b_fs, 0);
    end

`ifdef VGA_SYNC_FRAME_COUNT_EN
    // 257 frames of the small raster: counter wraps 255 -> 0 and then reads 1.
    for (int k = 1; k <= 257; k++) begin
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (b_fs) begin
          found = 1'b1;
          break;
        end
      end
      check("fc_frame_start_seen", found, 1);
      check("fc_value", b_fc, k % 256);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
